// File: rtl/io_stream_bridge.sv
// I/O port bridge: inbound/outbound 16-bit FIFOs between CPU strobes and external valid/ready streams.
// Latency: one edge to head in either direction; ext_in_ready drops when inbound full, io_wr to full outbound drops unless a pop coincides.

module io_stream_fifo #(
   parameter int DEPTH = 4,
   parameter int AW    = 2,
   parameter int W     = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  push_dat,
   input  logic          pop,
   output logic [W-1:0]  head_dat,
   output logic [AW:0]   count
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic          do_push, do_pop;

   // A full FIFO still takes a push when the head leaves on the same edge.
   assign do_pop   = pop & (count != '0);
   assign do_push  = push & ((count != FULL) | do_pop);
   assign head_dat = mem[rptr];

   always_ff @(posedge clk) begin
      if (reset && do_push)
         mem[wptr] <= push_dat;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push)
            wptr <= wptr + 1'b1;
         if (do_pop)
            rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

module io_stream_bridge #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          CLK,
   input  logic          reset,
   input  logic [15:0]   ext_in_data,
   input  logic          ext_in_valid,
   output logic          ext_in_ready,
   output logic [15:0]   io_in,
   input  logic          io_rd,
   input  logic [15:0]   io_out,
   input  logic          io_wr,
   output logic [15:0]   ext_out_data,
   output logic          ext_out_valid,
   input  logic          ext_out_ready,
   output logic [AW:0]   in_count,
   output logic [AW:0]   out_count,
   output logic          underflow,
   output logic          overflow
);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic        in_push, out_pop;
   logic [15:0] in_head;

   // Inbound readiness looks only at stored occupancy, never at a same-edge pop.
   assign ext_in_ready  = (in_count != FULL);
   assign in_push       = ext_in_valid & ext_in_ready;
   assign io_in         = (in_count != '0) ? in_head : 16'h0000;
   assign ext_out_valid = (out_count != '0);
   assign out_pop       = ext_out_valid & ext_out_ready;

   io_stream_fifo #(.DEPTH(DEPTH), .AW(AW), .W(16)) u_in_fifo (
      .clk      (CLK),
      .reset    (reset),
      .push     (in_push),
      .push_dat (ext_in_data),
      .pop      (io_rd),
      .head_dat (in_head),
      .count    (in_count)
   );

   io_stream_fifo #(.DEPTH(DEPTH), .AW(AW), .W(16)) u_out_fifo (
      .clk      (CLK),
      .reset    (reset),
      .push     (io_wr),
      .push_dat (io_out),
      .pop      (out_pop),
      .head_dat (ext_out_data),
      .count    (out_count)
   );

   always_ff @(posedge CLK) begin
      if (!reset) begin
         underflow <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (io_rd && in_count == '0)
            underflow <= 1'b1;
         if (io_wr && out_count == FULL && !out_pop)
            overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_io_stream_bridge.sv
// Directed bench for io_stream_bridge with hand-computed expectations.
module tb_io_stream_bridge;
   logic        CLK = 1'b0;
   logic        reset;
   logic [15:0] ext_in_data;
   logic        ext_in_valid;
   logic        ext_in_ready;
   logic [15:0] io_in;
   logic        io_rd;
   logic [15:0] io_out;
   logic        io_wr;
   logic [15:0] ext_out_data;
   logic        ext_out_valid;
   logic        ext_out_ready;
   logic [2:0]  in_count;
   logic [2:0]  out_count;
   logic        underflow;
   logic        overflow;

   int n_chk  = 0;
   int n_pass = 0;

   io_stream_bridge #(.DEPTH(4), .AW(2)) dut (
      .CLK           (CLK),
      .reset         (reset),
      .ext_in_data   (ext_in_data),
      .ext_in_valid  (ext_in_valid),
      .ext_in_ready  (ext_in_ready),
      .io_in         (io_in),
      .io_rd         (io_rd),
      .io_out        (io_out),
      .io_wr         (io_wr),
      .ext_out_data  (ext_out_data),
      .ext_out_valid (ext_out_valid),
      .ext_out_ready (ext_out_ready),
      .in_count      (in_count),
      .out_count     (out_count),
      .underflow     (underflow),
      .overflow      (overflow)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      ext_in_valid  = 1'b0;
      io_rd         = 1'b0;
      io_wr         = 1'b0;
   endtask

   logic [15:0] in_vals [4];

   initial begin
      in_vals[0] = 16'h1111; in_vals[1] = 16'h2222;
      in_vals[2] = 16'h3333; in_vals[3] = 16'h4444;

      // Reset held for two edges with strobes active
      reset = 1'b0; ext_in_valid = 1'b1; ext_in_data = 16'hDEAD;
      io_wr = 1'b1; io_out = 16'hBAD0; io_rd = 1'b0; ext_out_ready = 1'b0;
      step(); step();
      idle(); reset = 1'b1;
      #1;
      chk("rst_in_count", in_count, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_io_in", io_in, 16'h0000);
      chk("rst_ext_in_ready", ext_in_ready, 1);
      chk("rst_ext_out_valid", ext_out_valid, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_overflow", overflow, 0);

      // Inbound fill and order
      for (int k = 0; k < 4; k++) begin
         ext_in_valid = 1'b1; ext_in_data = in_vals[k];
         step();
         chk("in_fill_count", in_count, k + 1);
         chk("in_fill_head", io_in, 16'h1111);
      end
      chk("in_full_ready", ext_in_ready, 0);
      ext_in_data = 16'h5555;
      step();
      chk("in_full_hold_count", in_count, 4);
      chk("in_full_hold_head", io_in, 16'h1111);
      ext_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("in_order", io_in, in_vals[k]);
         io_rd = 1'b1;
         step();
      end
      io_rd = 1'b0;
      chk("in_empty_io_in", io_in, 16'h0000);
      chk("in_empty_count", in_count, 0);
      chk("in_no_underflow", underflow, 0);

      // Underflow with same-edge push
      io_rd = 1'b1; ext_in_valid = 1'b1; ext_in_data = 16'hABCD;
      step();
      idle();
      chk("uf_flag", underflow, 1);
      chk("uf_count", in_count, 1);
      chk("uf_io_in", io_in, 16'hABCD);
      io_rd = 1'b1;
      step();
      io_rd = 1'b0;
      chk("uf_drain_count", in_count, 0);
      chk("uf_sticky", underflow, 1);

      // Outbound backpressure and overflow
      ext_out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         io_wr = 1'b1; io_out = 16'(k);
         step();
      end
      io_wr = 1'b0;
      chk("ob_count", out_count, 4);
      chk("ob_overflow", overflow, 1);
      chk("ob_valid", ext_out_valid, 1);
      ext_out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("ob_order", ext_out_data, k);
         step();
      end
      ext_out_ready = 1'b0;
      chk("ob_drained_count", out_count, 0);
      chk("ob_drained_valid", ext_out_valid, 0);

      // Reset mid-transfer discards buffered words and clears flags
      ext_in_valid = 1'b1; ext_in_data = 16'h7777; io_wr = 1'b1; io_out = 16'h8888;
      step();
      idle(); reset = 1'b0;
      step();
      reset = 1'b1;
      #1;
      chk("rst2_in_count", in_count, 0);
      chk("rst2_out_count", out_count, 0);
      chk("rst2_underflow", underflow, 0);
      chk("rst2_overflow", overflow, 0);

      // Full bypass: write on a full FIFO while the head drains
      for (int k = 1; k <= 4; k++) begin
         io_wr = 1'b1; io_out = 16'h0010 + 16'(k);
         step();
      end
      io_wr = 1'b1; io_out = 16'hBEEF; ext_out_ready = 1'b1;
      step();
      io_wr = 1'b0; ext_out_ready = 1'b0;
      chk("byp_overflow", overflow, 0);
      chk("byp_count", out_count, 4);
      chk("byp_head", ext_out_data, 16'h0012);
      ext_out_ready = 1'b1;
      chk("byp_order0", ext_out_data, 16'h0012); step();
      chk("byp_order1", ext_out_data, 16'h0013); step();
      chk("byp_order2", ext_out_data, 16'h0014); step();
      chk("byp_order3", ext_out_data, 16'hBEEF); step();
      chk("byp_empty", out_count, 0);

      // Concurrent streaming in both directions across pointer wrap
      for (int k = 0; k < 20; k++) begin
         ext_in_valid = 1'b1; ext_in_data = 16'h0100 + 16'(k);
         io_rd = (k != 0);
         io_wr = 1'b1; io_out = 16'h0200 + 16'(k);
         step();
         chk("cc_io_in", io_in, 16'h0100 + 16'(k));
         chk("cc_in_count", in_count, 1);
         chk("cc_out_data", ext_out_data, 16'h0200 + 16'(k));
         chk("cc_out_count", out_count, 1);
      end
      idle();
      chk("cc_underflow", underflow, 0);
      chk("cc_overflow", overflow, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/io_stream_bridge.md
Name: io_stream_bridge

Overview:
- Device-side counterpart of the accumulator CPU's 16-bit I/O port.
- Sources the word the CPU reads on its `memIn` I/O input and sinks the word the CPU writes on its I/O output.
- Decouples both directions from external valid/ready streams through two small FIFOs (inbound and outbound).
- Sits at the top level beside the CPU; the memory subsystem supplies one-cycle read/write strobes when an I/O access executes.

Parameters:
- DEPTH, 4, entries per FIFO; power of two, >= 2.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the CLK rising edge.
- ext_in_data  in  16  inbound word from external producer.
- ext_in_valid  in  1  ext_in_data valid.
- ext_in_ready  out  1  inbound FIFO can accept.
- io_in  out  16  word presented to CPU I/O input (`memIn`).
- io_rd  in  1  CPU read-strobe pulse; pops inbound FIFO.
- io_out  in  16  CPU I/O output word.
- io_wr  in  1  CPU write-strobe pulse; pushes io_out into outbound FIFO.
- ext_out_data  out  16  outbound head word.
- ext_out_valid  out  1  outbound FIFO non-empty.
- ext_out_ready  in  1  external consumer accepts.
- in_count  out  AW+1  inbound occupancy.
- out_count  out  AW+1  outbound occupancy.
- underflow  out  1  sticky: io_rd seen while inbound FIFO empty.
- overflow  out  1  sticky: io_wr dropped because outbound FIFO full.

Behaviour:
- Reset (reset==0 at a CLK edge):
  - Pointers and counts go to 0; underflow and overflow go to 0.
  - Resulting outputs: ext_in_ready=1, ext_out_valid=0, io_in=16'h0000.
  - Reset mid-transfer discards all buffered words. No handshake completes on a reset edge.
- Inbound FIFO (ext -> CPU):
  - ext_in_ready = (in_count != DEPTH). It depends on stored state only; it does not anticipate a same-cycle pop.
  - Push when ext_in_valid & ext_in_ready at an edge.
  - io_in = head word when in_count != 0, else 16'h0000. io_in is combinational from FIFO storage.
  - Latency: a word pushed at edge N appears on io_in after edge N when the FIFO was empty.
  - Pop when io_rd at an edge and in_count != 0.
  - io_rd with in_count == 0: no pointer change; sets underflow. A same-edge push still occurs.
  - Simultaneous push and pop with 0 < in_count < DEPTH: count unchanged, both pointers advance.
- Outbound FIFO (CPU -> ext):
  - ext_out_valid = (out_count != 0); ext_out_data = head word.
  - Pop when ext_out_valid & ext_out_ready at an edge.
  - Push of io_out when io_wr at an edge, if out_count < DEPTH OR a pop occurs on the same edge.
  - io_wr when full with no same-edge pop: word dropped; sets overflow.
  - Latency: a word written at edge N is visible on ext_out_data after edge N when the FIFO was empty.
- Pointers:
  - AW bits each; wrap from DEPTH-1 to 0.
  - Counts are AW+1 bits: +1 on push only, -1 on pop only, unchanged on both or neither.
- Sticky flags:
  - underflow and overflow clear only on reset.
  - Multiple events keep the flag at 1.
- Data path: word order preserved per direction. No width conversion; all data is 16 bits unsigned, passed unmodified.
- io_rd and io_wr may be high on the same edge; the two directions are independent.
- Strobes held high for multiple cycles act as one operation per edge.

Test Plan:
- Reset check: hold reset=0 for 2 edges while ext_in_valid=1 and io_wr=1. Release -> in_count=0, out_count=0, io_in=0000, ext_in_ready=1, ext_out_valid=0, flags=0.
- Inbound order: push 1111, 2222, 3333, 4444. Then ext_in_ready=0 with ext_in_valid held and in_count=4. Pulse io_rd 4 times -> io_in sequence 1111, 2222, 3333, 4444, then 0000 with in_count=0.
- Underflow: io_rd with empty inbound FIFO, same edge as push of ABCD -> underflow=1, in_count=1, io_in=ABCD.
- Outbound backpressure: ext_out_ready=0; io_wr with 0001..0005 -> out_count=4, overflow=1, 0005 dropped. Raise ready -> ext_out_data 0001..0004 in order.
- Full bypass: outbound full; io_wr=1 (io_out=BEEF) on the same edge as ext_out_ready=1 -> overflow unchanged, out_count stays 4, BEEF drained last.
- Concurrent traffic: continuous ext_in stream 0100+k with io_rd every cycle, plus io_wr every cycle with ext_out_ready=1 -> both counts stay <= 1, no flags set, order preserved across 20 words including pointer wrap.
